// File: rtl/retospect_cfg_loader.sv
// Configuration scan-chain loader: streams bytes LSB-first into the neurochip chain,
// returns the bits shifted out as readback bytes, then pulses the network reset.

module retospect_cfg_loader #(
    parameter int unsigned CHAIN_LEN       = 523,
    parameter int unsigned NN_RESET_CYCLES = 2,
    parameter int unsigned CNT_W           = $clog2(CHAIN_LEN + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       cfg_en,
    output logic       cfg_bs,
    input  logic       cfg_bs_ret,
    output logic       net_reset,
    output logic       busy,
    output logic       done
);

    localparam int unsigned      NN_W     = (NN_RESET_CYCLES > 1) ? $clog2(NN_RESET_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [NN_W-1:0]  NN_LAST  = NN_W'(NN_RESET_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        NNRST,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       byte_idx;
    logic [3:0]       byte_bits;
    logic [7:0]       sreg;
    logic [7:0]       rbuf;
    logic [7:0]       rbuf_nx;
    logic [NN_W-1:0]  nn_cnt;
    logic [CNT_W-1:0] remaining;
    logic [3:0]       fetch_bits;
    logic             last_bit;
    logic             chain_end;
    logic             accept;
    logic             shift_step;

    // Bits still owed to the chain decide how much of the fetched byte is used;
    // a short final byte simply ends the SHIFT phase early.
    always_comb begin
        remaining  = CNT_W'(CHAIN_LEN) - bit_cnt;
        fetch_bits = (remaining > CNT_W'(7)) ? 4'd8 : 4'(remaining);
        last_bit   = (({1'b0, byte_idx} + 4'd1) == byte_bits);
        chain_end  = (bit_cnt == LAST_CNT);
        rbuf_nx    = rbuf | (8'(cfg_bs_ret) << byte_idx);
        accept     = (state == FETCH) && in_valid && !abort;
        shift_step = (state == SHIFT) && !abort;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        cfg_en    = 1'b0;
        cfg_bs    = 1'b0;
        net_reset = 1'b0;
        busy      = (state != IDLE);
        done      = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) state_nx = FETCH;
            end
            FETCH: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = SHIFT;
            end
            SHIFT: begin
                cfg_en = !abort;
                cfg_bs = sreg[0];
                if (last_bit) state_nx = chain_end ? NNRST : FETCH;
            end
            NNRST: begin
                net_reset = !abort;
                if (nn_cnt == NN_LAST) state_nx = DONE;
            end
            DONE: begin
                done     = !abort;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        if (abort) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            byte_idx  <= '0;
            byte_bits <= '0;
            sreg      <= '0;
            rbuf      <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            nn_cnt    <= '0;
        end else begin
            rd_valid <= 1'b0;

            if ((state == IDLE) && start && !abort) begin
                bit_cnt <= '0;
            end

            if (accept) begin
                sreg      <= in_data;
                byte_bits <= fetch_bits;
                byte_idx  <= '0;
                rbuf      <= '0;
            end

            if (shift_step) begin
                sreg     <= {1'b0, sreg[7:1]};
                bit_cnt  <= bit_cnt + CNT_W'(1);
                byte_idx <= byte_idx + 3'd1;
                rbuf     <= rbuf_nx;
                if (last_bit) begin
                    rd_valid <= 1'b1;
                    rd_data  <= rbuf_nx;
                end
            end

            if (state == NNRST) begin
                nn_cnt <= nn_cnt + NN_W'(1);
            end else begin
                nn_cnt <= '0;
            end
        end
    end

    a_en_excl : assert property (@(posedge clk) disable iff (!rst_n) !(cfg_en && net_reset));
    a_done_idle : assert property (@(posedge clk) disable iff (!rst_n) done |=> (state == IDLE));

endmodule

// File: tb/tb_retospect_cfg_loader.sv
// Bench for retospect_cfg_loader: a 20-bit and a 523-bit chain model, readback scoreboard.

module tb_retospect_cfg_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic       s_rst_n, s_start, s_abort, s_in_valid, s_in_ready, s_rd_valid;
    logic [7:0] s_in_data, s_rd_data;
    logic       s_cfg_en, s_cfg_bs, s_cfg_bs_ret, s_net_reset, s_busy, s_done;

    logic       b_rst_n, b_start, b_abort, b_in_valid, b_in_ready, b_rd_valid;
    logic [7:0] b_in_data, b_rd_data;
    logic       b_cfg_en, b_cfg_bs, b_cfg_bs_ret, b_net_reset, b_busy, b_done;

    retospect_cfg_loader #(.CHAIN_LEN(20), .NN_RESET_CYCLES(2)) u_small (
        .clk(clk), .rst_n(s_rst_n), .start(s_start), .abort(s_abort),
        .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .rd_data(s_rd_data), .rd_valid(s_rd_valid), .cfg_en(s_cfg_en),
        .cfg_bs(s_cfg_bs), .cfg_bs_ret(s_cfg_bs_ret), .net_reset(s_net_reset),
        .busy(s_busy), .done(s_done)
    );

    retospect_cfg_loader u_big (
        .clk(clk), .rst_n(b_rst_n), .start(b_start), .abort(b_abort),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .cfg_en(b_cfg_en),
        .cfg_bs(b_cfg_bs), .cfg_bs_ret(b_cfg_bs_ret), .net_reset(b_net_reset),
        .busy(b_busy), .done(b_done)
    );

    // Chain models: bit entering at the top, bs_out taken from bit 0.
    logic [19:0]  s_chain = '0;
    logic [19:0]  s_pre_val;
    logic         s_pre_en;
    logic [522:0] b_chain = '0;
    logic [522:0] b_pre_val;
    logic         b_pre_en;

    always @(posedge clk) begin
        if (s_pre_en) s_chain <= s_pre_val;
        else if (s_cfg_en) s_chain <= {s_cfg_bs, s_chain[19:1]};
        if (b_pre_en) b_chain <= b_pre_val;
        else if (b_cfg_en) b_chain <= {b_cfg_bs, b_chain[522:1]};
    end
    assign s_cfg_bs_ret = s_chain[0];
    assign b_cfg_bs_ret = b_chain[0];

    int s_cfg_cnt = 0, s_nn_cnt = 0, s_done_cnt = 0, s_acc_cnt = 0;
    int b_cfg_cnt = 0, b_nn_cnt = 0, b_done_cnt = 0, b_acc_cnt = 0;
    logic [7:0] s_exp[$], s_obs[$], b_exp[$], b_obs[$];
    logic [19:0]  s_img = '0;
    logic [522:0] b_img = '0;

    task automatic tick();
        @(negedge clk);
        if (s_cfg_en) s_cfg_cnt++;
        if (s_net_reset) s_nn_cnt++;
        if (s_done) s_done_cnt++;
        if (s_in_valid && s_in_ready) s_acc_cnt++;
        if (s_rd_valid) s_obs.push_back(s_rd_data);
        if (b_cfg_en) b_cfg_cnt++;
        if (b_net_reset) b_nn_cnt++;
        if (b_done) b_done_cnt++;
        if (b_in_valid && b_in_ready) b_acc_cnt++;
        if (b_rd_valid) b_obs.push_back(b_rd_data);
        @(posedge clk);
        #1;
    endtask

    task automatic s_preload(input logic [19:0] v);
        s_pre_val = v;
        s_pre_en  = 1'b1;
        tick();
        s_pre_en  = 1'b0;
        s_img     = v;
    endtask

    task automatic s_predict(input logic [7:0] d [3], output logic [19:0] nimg);
        logic [7:0] e;
        nimg = s_img;
        for (int k = 0; k < 3; k++) begin
            e = '0;
            for (int i = 0; i < 8; i++) begin
                if (8 * k + i < 20) begin
                    e[i] = s_img[8 * k + i];
                    nimg[8 * k + i] = d[k][i];
                end
            end
            s_exp.push_back(e);
        end
    endtask

    task automatic s_send(input logic [7:0] d, output bit ok);
        int t = 0;
        while (!s_in_ready && t < 40) begin
            tick();
            t++;
        end
        ok = s_in_ready;
        if (ok) begin
            s_in_data  = d;
            s_in_valid = 1'b1;
            tick();
            s_in_valid = 1'b0;
        end
    endtask

    task automatic s_wait_idle(output bit ok);
        int t = 0;
        while (s_busy && t < 60) begin
            tick();
            t++;
        end
        ok = !s_busy;
    endtask

    task automatic s_load(input logic [7:0] d [3], output bit ok);
        logic [19:0] nimg;
        bit sok;
        ok = 1'b1;
        s_predict(d, nimg);
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_send(d[k], sok);
            ok &= sok;
        end
        s_wait_idle(sok);
        ok &= sok;
        s_img = nimg;
    endtask

    task automatic test_reset();
        s_rst_n = 1'b0;
        b_rst_n = 1'b0;
        repeat (2) tick();
        n_checks++;
        if ({s_in_ready, s_rd_valid, s_cfg_en, s_cfg_bs, s_net_reset, s_busy, s_done, s_rd_data} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_small_outputs: got %b, expected all zero",
                     {s_in_ready, s_rd_valid, s_cfg_en, s_cfg_bs, s_net_reset, s_busy, s_done, s_rd_data});
        end
        n_checks++;
        if ({b_in_ready, b_rd_valid, b_cfg_en, b_cfg_bs, b_net_reset, b_busy, b_done, b_rd_data} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_big_outputs: got %b, expected all zero",
                     {b_in_ready, b_rd_valid, b_cfg_en, b_cfg_bs, b_net_reset, b_busy, b_done, b_rd_data});
        end
        s_rst_n = 1'b1;
        b_rst_n = 1'b1;
        tick();
        n_checks++;
        if ({s_busy, s_in_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_release_idle: got busy,in_ready=%b, expected 00", {s_busy, s_in_ready});
        end
    endtask

    task automatic test_readback();
        logic [7:0] d [3];
        logic [7:0] got, want;
        bit ok;
        s_preload(20'hFFFFF);
        d = '{8'h00, 8'h00, 8'h00};
        s_load(d, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL readback_handshake: got timeout, expected completion"); end
        n_checks++;
        if (s_obs.size() != 3) begin
            n_fail++;
            $display("FAIL readback_count: got %0d rd_valid pulses, expected 3", s_obs.size());
        end
        while (s_obs.size() > 0 && s_exp.size() > 0) begin
            got  = s_obs.pop_front();
            want = s_exp.pop_front();
            n_checks++;
            if (got !== want) begin n_fail++; $display("FAIL readback_byte: got %02h, expected %02h", got, want); end
        end
        s_obs.delete();
        s_exp.delete();
        n_checks++;
        if (s_rd_data !== 8'h0F) begin
            n_fail++;
            $display("FAIL readback_hold: got rd_data %02h, expected 0f held", s_rd_data);
        end
        n_checks++;
        if (s_chain !== 20'h00000) begin
            n_fail++;
            $display("FAIL readback_chain: got %05h, expected 00000", s_chain);
        end
    endtask

    task automatic test_load();
        logic [7:0] d [3];
        logic [7:0] got, want;
        int c0, n0, dn0, a0;
        bit ok;
        c0 = s_cfg_cnt; n0 = s_nn_cnt; dn0 = s_done_cnt; a0 = s_acc_cnt;
        d = '{8'hA5, 8'h3C, 8'h0F};
        s_load(d, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL load_handshake: got timeout, expected completion"); end
        n_checks++;
        if (s_cfg_cnt - c0 != 20) begin n_fail++; $display("FAIL load_cfg_en_cycles: got %0d, expected 20", s_cfg_cnt - c0); end
        n_checks++;
        if (s_chain !== 20'hF3CA5) begin n_fail++; $display("FAIL load_chain: got %05h, expected f3ca5", s_chain); end
        n_checks++;
        if (s_nn_cnt - n0 != 2) begin n_fail++; $display("FAIL load_net_reset_cycles: got %0d, expected 2", s_nn_cnt - n0); end
        n_checks++;
        if (s_done_cnt - dn0 != 1) begin n_fail++; $display("FAIL load_done_pulses: got %0d, expected 1", s_done_cnt - dn0); end
        n_checks++;
        if (s_acc_cnt - a0 != 3) begin n_fail++; $display("FAIL load_bytes_accepted: got %0d, expected 3", s_acc_cnt - a0); end
        n_checks++;
        if (s_obs.size() != 3) begin n_fail++; $display("FAIL load_rd_count: got %0d, expected 3", s_obs.size()); end
        while (s_obs.size() > 0 && s_exp.size() > 0) begin
            got  = s_obs.pop_front();
            want = s_exp.pop_front();
            n_checks++;
            if (got !== want) begin n_fail++; $display("FAIL load_rd_byte: got %02h, expected %02h", got, want); end
        end
        s_obs.delete();
        s_exp.delete();
    endtask

    task automatic test_back_to_back();
        logic [7:0] d [3];
        logic [7:0] got, want;
        int c0;
        bit ok;
        c0 = s_cfg_cnt;
        d = '{8'h11, 8'h22, 8'hF7};
        s_load(d, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL b2b_handshake: got timeout, expected completion"); end
        n_checks++;
        if (s_chain !== 20'h72211) begin n_fail++; $display("FAIL b2b_chain_extra_bits: got %05h, expected 72211", s_chain); end
        n_checks++;
        if (s_cfg_cnt - c0 != 20) begin n_fail++; $display("FAIL b2b_cfg_en_cycles: got %0d, expected 20", s_cfg_cnt - c0); end
        n_checks++;
        if (s_obs.size() != 3) begin n_fail++; $display("FAIL b2b_rd_count: got %0d, expected 3", s_obs.size()); end
        while (s_obs.size() > 0 && s_exp.size() > 0) begin
            got  = s_obs.pop_front();
            want = s_exp.pop_front();
            n_checks++;
            if (got !== want) begin n_fail++; $display("FAIL b2b_rd_byte: got %02h, expected %02h", got, want); end
        end
        s_obs.delete();
        s_exp.delete();
    endtask

    task automatic test_stall();
        logic [7:0] d [3];
        logic [7:0] got, want;
        logic [19:0] nimg, snap;
        int c0, t;
        bit ok, sok;
        c0 = s_cfg_cnt;
        d = '{8'hC3, 8'h96, 8'h5B};
        s_predict(d, nimg);
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        s_send(d[0], ok);
        t = 0;
        while (!s_in_ready && t < 40) begin tick(); t++; end
        snap = s_chain;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) s_start = 1'b1;
            #1;
            n_checks++;
            if ({s_cfg_en, s_in_ready} !== 2'b01 || s_chain !== snap) begin
                n_fail++;
                $display("FAIL stall_cycle%0d: got cfg_en,in_ready=%b chain=%05h, expected 01 chain=%05h",
                         c, {s_cfg_en, s_in_ready}, s_chain, snap);
            end
            tick();
            s_start = 1'b0;
        end
        s_send(d[1], sok); ok &= sok;
        s_send(d[2], sok); ok &= sok;
        s_wait_idle(sok); ok &= sok;
        s_img = nimg;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL stall_handshake: got timeout, expected completion"); end
        n_checks++;
        if (s_chain !== nimg) begin n_fail++; $display("FAIL stall_chain: got %05h, expected %05h", s_chain, nimg); end
        n_checks++;
        if (s_cfg_cnt - c0 != 20) begin n_fail++; $display("FAIL stall_cfg_en_cycles: got %0d, expected 20", s_cfg_cnt - c0); end
        while (s_obs.size() > 0 && s_exp.size() > 0) begin
            got  = s_obs.pop_front();
            want = s_exp.pop_front();
            n_checks++;
            if (got !== want) begin n_fail++; $display("FAIL stall_rd_byte: got %02h, expected %02h", got, want); end
        end
        n_checks++;
        if (s_obs.size() != 0 || s_exp.size() != 0) begin
            n_fail++;
            $display("FAIL stall_rd_count: got %0d leftover observed, %0d leftover expected, expected 0", s_obs.size(), s_exp.size());
        end
        s_obs.delete();
        s_exp.delete();
    endtask

    task automatic test_abort();
        logic [7:0] d [3];
        logic [7:0] got, want, e;
        logic [19:0] nimg;
        int c0, dn0;
        bit ok, sok;
        c0 = s_cfg_cnt; dn0 = s_done_cnt;
        e = s_img[7:0];
        s_exp.push_back(e);
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        s_send(8'h5A, ok);
        s_send(8'hC3, sok); ok &= sok;
        repeat (3) tick();
        s_abort = 1'b1;
        #1;
        n_checks++;
        if ({s_cfg_en, s_busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL abort_cfg_en: got cfg_en,busy=%b, expected 01", {s_cfg_en, s_busy});
        end
        tick();
        s_abort = 1'b0;
        n_checks++;
        if ({s_busy, s_in_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_idle: got busy,in_ready=%b, expected 00", {s_busy, s_in_ready});
        end
        repeat (3) tick();
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL abort_handshake: got timeout, expected acceptance"); end
        n_checks++;
        if (s_cfg_cnt - c0 != 11) begin n_fail++; $display("FAIL abort_shifted_bits: got %0d, expected 11", s_cfg_cnt - c0); end
        n_checks++;
        if (s_done_cnt != dn0) begin n_fail++; $display("FAIL abort_no_done: got %0d done pulses, expected 0", s_done_cnt - dn0); end
        n_checks++;
        if (s_obs.size() != 1) begin n_fail++; $display("FAIL abort_rd_count: got %0d, expected 1", s_obs.size()); end
        while (s_obs.size() > 0 && s_exp.size() > 0) begin
            got  = s_obs.pop_front();
            want = s_exp.pop_front();
            n_checks++;
            if (got !== want) begin n_fail++; $display("FAIL abort_rd_byte: got %02h, expected %02h", got, want); end
        end
        s_obs.delete();
        s_exp.delete();
        nimg  = (s_img >> 11) | (20'(11'h35A) << 9);
        s_img = nimg;
        n_checks++;
        if (s_chain !== nimg) begin n_fail++; $display("FAIL abort_chain: got %05h, expected %05h", s_chain, nimg); end

        c0 = s_cfg_cnt;
        d = '{8'h01, 8'h80, 8'h06};
        s_load(d, ok);
        n_checks++;
        if (!ok || s_chain !== 20'h68001) begin
            n_fail++;
            $display("FAIL abort_reload_chain: got %05h ok=%0d, expected 68001 ok=1", s_chain, ok);
        end
        n_checks++;
        if (s_cfg_cnt - c0 != 20) begin n_fail++; $display("FAIL abort_reload_cfg_en: got %0d, expected 20", s_cfg_cnt - c0); end
        n_checks++;
        if (s_obs.size() != 3) begin n_fail++; $display("FAIL abort_reload_rd_count: got %0d, expected 3", s_obs.size()); end
        while (s_obs.size() > 0 && s_exp.size() > 0) begin
            got  = s_obs.pop_front();
            want = s_exp.pop_front();
            n_checks++;
            if (got !== want) begin n_fail++; $display("FAIL abort_reload_rd_byte: got %02h, expected %02h", got, want); end
        end
        s_obs.delete();
        s_exp.delete();
    endtask

    task automatic test_start_abort();
        s_start = 1'b1;
        s_abort = 1'b1;
        tick();
        s_start = 1'b0;
        s_abort = 1'b0;
        n_checks++;
        if ({s_busy, s_in_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL start_abort_same_cycle: got busy,in_ready=%b, expected 00", {s_busy, s_in_ready});
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d [3];
        logic [7:0] got, want;
        logic [19:0] nimg;
        int dn0, t;
        bit ok, sok;
        dn0 = s_done_cnt;
        d = '{8'h3E, 8'hD1, 8'h09};
        s_predict(d, nimg);
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_send(d[k], sok);
            ok &= sok;
        end
        t = 0;
        while (!s_net_reset && t < 40) begin tick(); t++; end
        n_checks++;
        if (!ok || !s_net_reset) begin
            n_fail++;
            $display("FAIL rstmid_reach_nnrst: got net_reset=%b ok=%0d, expected 1 ok=1", s_net_reset, ok);
        end
        tick();
        #2;
        s_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({s_net_reset, s_busy, s_cfg_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL rstmid_async: got net_reset,busy,cfg_en=%b, expected 000", {s_net_reset, s_busy, s_cfg_en});
        end
        tick();
        s_rst_n = 1'b1;
        tick();
        s_img = nimg;
        n_checks++;
        if (s_done_cnt != dn0 || s_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_no_done: got %0d done pulses busy=%b, expected 0 busy=0", s_done_cnt - dn0, s_busy);
        end
        n_checks++;
        if (s_obs.size() != 3) begin n_fail++; $display("FAIL rstmid_rd_count: got %0d, expected 3", s_obs.size()); end
        while (s_obs.size() > 0 && s_exp.size() > 0) begin
            got  = s_obs.pop_front();
            want = s_exp.pop_front();
            n_checks++;
            if (got !== want) begin n_fail++; $display("FAIL rstmid_rd_byte: got %02h, expected %02h", got, want); end
        end
        s_obs.delete();
        s_exp.delete();
    endtask

    task automatic test_full_len();
        logic [522:0] v, nimg;
        logic [7:0] d, e, got, want, last;
        int c0, n0, dn0, a0, t;
        bit ok;
        for (int i = 0; i < 523; i++) v[i] = 1'($urandom_range(0, 1));
        b_pre_val = v;
        b_pre_en  = 1'b1;
        tick();
        b_pre_en  = 1'b0;
        b_img     = v;
        c0 = b_cfg_cnt; n0 = b_nn_cnt; dn0 = b_done_cnt; a0 = b_acc_cnt;
        nimg = b_img;
        ok = 1'b1;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int k = 0; k < 66; k++) begin
            d = 8'($urandom);
            e = '0;
            for (int i = 0; i < 8; i++) begin
                if (8 * k + i < 523) begin
                    e[i] = b_img[8 * k + i];
                    nimg[8 * k + i] = d[i];
                end
            end
            b_exp.push_back(e);
            t = 0;
            while (!b_in_ready && t < 40) begin tick(); t++; end
            if (!b_in_ready) ok = 1'b0;
            b_in_data  = d;
            b_in_valid = 1'b1;
            tick();
            b_in_valid = 1'b0;
        end
        t = 0;
        while (b_busy && t < 100) begin tick(); t++; end
        if (b_busy) ok = 1'b0;
        b_img = nimg;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL full_handshake: got timeout, expected completion"); end
        n_checks++;
        if (b_acc_cnt - a0 != 66) begin n_fail++; $display("FAIL full_bytes_accepted: got %0d, expected 66", b_acc_cnt - a0); end
        n_checks++;
        if (b_cfg_cnt - c0 != 523) begin n_fail++; $display("FAIL full_cfg_en_cycles: got %0d, expected 523", b_cfg_cnt - c0); end
        n_checks++;
        if (b_nn_cnt - n0 != 2 || b_done_cnt - dn0 != 1) begin
            n_fail++;
            $display("FAIL full_nnrst_done: got net_reset=%0d done=%0d, expected 2 and 1", b_nn_cnt - n0, b_done_cnt - dn0);
        end
        n_checks++;
        if (b_chain !== nimg) begin n_fail++; $display("FAIL full_chain: got low word %08h, expected %08h", b_chain[31:0], nimg[31:0]); end
        n_checks++;
        if (b_obs.size() != 66) begin n_fail++; $display("FAIL full_rd_count: got %0d, expected 66", b_obs.size()); end
        last = (b_obs.size() > 0) ? b_obs[b_obs.size() - 1] : 8'hFF;
        n_checks++;
        if (last[7:3] !== 5'd0) begin n_fail++; $display("FAIL full_last_upper: got %02h, expected bits [7:3]=0", last); end
        while (b_obs.size() > 0 && b_exp.size() > 0) begin
            got  = b_obs.pop_front();
            want = b_exp.pop_front();
            n_checks++;
            if (got !== want) begin n_fail++; $display("FAIL full_rd_byte: got %02h, expected %02h", got, want); end
        end
        b_obs.delete();
        b_exp.delete();
    endtask

    initial begin
        s_start = 1'b0; s_abort = 1'b0; s_in_valid = 1'b0; s_in_data = '0;
        b_start = 1'b0; b_abort = 1'b0; b_in_valid = 1'b0; b_in_data = '0;
        s_pre_en = 1'b0; s_pre_val = '0; b_pre_en = 1'b0; b_pre_val = '0;
        s_rst_n = 1'b0; b_rst_n = 1'b0;
        test_reset();
        test_readback();
        test_load();
        test_back_to_back();
        test_stall();
        test_abort();
        test_start_abort();
        test_reset_mid();
        test_full_len();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
